// File: rtl/scr1_dmem_ahb_bridge.sv
// rtl/scr1_dmem_ahb_bridge.sv - LSU data-memory port to AHB-Lite master bridge
module scr1_dmem_ahb_bridge #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        clk,
    input  logic        rst_n,
    // LSU side
    input  logic        dmem_req,
    input  logic        dmem_cmd,
    input  logic [1:0]  dmem_width,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_req_ack,
    output logic [31:0] dmem_rdata,
    output logic [1:0]  dmem_resp,
    // AHB-Lite master side
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    localparam logic [1:0] RESP_IDLE  = 2'd0;
    localparam logic [1:0] RESP_OK    = 2'd1;
    localparam logic [1:0] RESP_ER    = 2'd2;
    localparam logic [1:0] HTRANS_IDL = 2'b00;
    localparam logic [1:0] HTRANS_NSQ = 2'b10;

    state_e      state_q, state_d;
    logic        cmd_q;
    logic [1:0]  width_q;
    logic [1:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wdata_aligned;

    // Place store data on the byte lanes selected by the low address bits
    always_comb begin
        wdata_aligned = dmem_wdata;
        case (dmem_width)
            2'd0:    wdata_aligned = {24'd0, dmem_wdata[7:0]}  << {dmem_addr[1:0], 3'b000};
            2'd1:    wdata_aligned = {16'd0, dmem_wdata[15:0]} << {dmem_addr[1], 4'b0000};
            default: wdata_aligned = dmem_wdata;
        endcase
    end

    // State register and per-transfer context captured on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= 1'b0;
            width_q <= 2'd0;
            addr_q  <= 2'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (dmem_req_ack) begin
                cmd_q   <= dmem_cmd;
                width_q <= dmem_width;
                addr_q  <= dmem_addr[1:0];
                wdata_q <= wdata_aligned;
            end
        end
    end

    // Next state plus address-phase, data-phase and LSU response outputs
    always_comb begin
        state_d      = state_q;
        dmem_req_ack = 1'b0;
        dmem_resp    = RESP_IDLE;
        htrans       = HTRANS_IDL;
        haddr        = 32'd0;
        hwrite       = 1'b0;
        hsize        = 3'b010;
        hwdata       = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (dmem_req) begin
                    htrans       = HTRANS_NSQ;
                    haddr        = dmem_addr;
                    hwrite       = dmem_cmd;
                    // reserved width is issued as a word access
                    hsize        = (dmem_width == 2'd3) ? 3'b010 : {1'b0, dmem_width};
                    dmem_req_ack = hready;
                    if (hready) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                hwdata = wdata_q;
                // hready low with hresp high is the first ERROR cycle: keep waiting
                if (hready) begin
                    dmem_resp = hresp ? RESP_ER : RESP_OK;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Right-justify load data from the lanes the transfer occupied
    always_comb begin
        dmem_rdata = 32'd0;
        if ((state_q == ST_DATA) && hready && !hresp && !cmd_q) begin
            case (width_q)
                2'd0:    dmem_rdata = hrdata >> {addr_q, 3'b000};
                2'd1:    dmem_rdata = hrdata >> {addr_q[1], 4'b0000};
                default: dmem_rdata = hrdata;
            endcase
        end
    end

    assign hburst = 3'b000;
    assign hprot  = HPROT_VAL;

endmodule

// File: doc/scr1_dmem_ahb_bridge.md
SCR1_DMEM_AHB_BRIDGE -- requirements
Module: scr1_dmem_ahb_bridge

Interface
REQ-001 SHALL have parameter HPROT_VAL, default 4'b0011, constant value driven on hprot (data access, privileged).
REQ-002 SHALL have port clk  input  1  core clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port dmem_req  input  1  request from LSU, held until dmem_req_ack.
REQ-005 SHALL have port dmem_cmd  input  1  0=RD, 1=WR.
REQ-006 SHALL have port dmem_width  input  2  0=BYTE, 1=HWORD, 2=WORD, 3=reserved.
REQ-007 SHALL have port dmem_addr  input  32  byte address.
REQ-008 SHALL have port dmem_wdata  input  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-009 SHALL have port dmem_req_ack  output  1  request accepted this cycle.
REQ-010 SHALL have port dmem_rdata  output  32  load data, right-justified.
REQ-011 SHALL have port dmem_resp  output  2  0=IDLE, 1=RDY_OK, 2=RDY_ER.
REQ-012 SHALL have AHB-Lite master ports: htrans output 2, haddr output 32, hwrite output 1, hsize output 3, hburst output 3, hprot output 4, hwdata output 32, hrdata input 32, hready input 1, hresp input 1 (0=OKAY, 1=ERROR).

Function
REQ-013 SHALL implement FSM with states IDLE and DATA; at most one outstanding transfer.
REQ-014 In IDLE with dmem_req=1, SHALL drive htrans=NONSEQ (2'b10), haddr=dmem_addr, hwrite=dmem_cmd, hsize={1'b0,width} (reserved width -> 3'b010), combinationally.
REQ-015 In IDLE with dmem_req=0, and always in DATA, SHALL drive htrans=IDLE (2'b00).
REQ-016 SHALL drive hburst=3'b000 (SINGLE) and hprot=HPROT_VAL constantly.
REQ-017 dmem_req_ack SHALL equal (state==IDLE) & dmem_req & hready; it is the only IDLE->DATA condition.
REQ-018 On acceptance SHALL register cmd, width, addr[1:0] and lane-aligned write data.
REQ-019 Write lane alignment: BYTE -> wdata[7:0] shifted left by 8*addr[1:0]; HWORD -> wdata[15:0] shifted left by 16*addr[1]; WORD -> unchanged; unused lanes zero.
REQ-020 hwdata SHALL present registered aligned data throughout DATA; zero in IDLE.
REQ-021 In DATA, hready=1 & hresp=0 SHALL give dmem_resp=RDY_OK for exactly that cycle and return to IDLE next cycle.
REQ-022 In DATA, hready=1 & hresp=1 SHALL give dmem_resp=RDY_ER for exactly that cycle and return to IDLE; hready=0 & hresp=1 (first ERROR cycle) SHALL keep waiting with dmem_resp=IDLE.
REQ-023 In DATA with hready=0, SHALL hold state, dmem_resp=IDLE, unbounded wait.
REQ-024 On RDY_OK read, dmem_rdata SHALL be hrdata shifted right by 8*addr_r[1:0] (BYTE) or 16*addr_r[1] (HWORD), else hrdata; upper bits beyond width are don't-care (LSU extends); zero when dmem_resp!=RDY_OK or write.
REQ-025 Misaligned addresses SHALL be passed through unchanged without checking (LSU filters them).
REQ-026 Minimum transaction: accept in cycle N, response in cycle N+1; next acceptance no earlier than N+2.
REQ-027 dmem_resp SHALL never be nonzero in IDLE.

Reset
REQ-028 rst_n=0 SHALL force state=IDLE, registered cmd/width/addr/wdata=0 asynchronously.
REQ-029 During/after reset: htrans=IDLE, hwdata=0, dmem_resp=IDLE, dmem_rdata=0, dmem_req_ack=0 unless dmem_req=1 and hready=1.
REQ-030 Reset asserted in DATA SHALL abandon the transfer; no response is issued for it.

Verification
REQ-031 SW addr=0x100 wdata=0xDEADBEEF, hready=1 -> ack cycle N (htrans=2, hsize=2, hwrite=1), hwdata=0xDEADBEEF N+1, RDY_OK N+1.
REQ-032 SB addr=0x203 wdata=0x000000A5 -> hsize=0, hwdata=0xA5000000, RDY_OK.
REQ-033 LH addr=0x302, hrdata=0x1234ABCD, 2 wait states -> dmem_resp=IDLE two cycles, then RDY_OK with dmem_rdata[15:0]=0x1234.
REQ-034 LW addr=0x400, slave ERROR (hready=0/hresp=1 then hready=1/hresp=1) -> RDY_ER on second cycle only, then IDLE, next req accepted following cycle.
REQ-035 dmem_req=1 in IDLE with hready=0 -> dmem_req_ack=0, no state change until hready=1.
REQ-036 rst_n low during DATA wait -> htrans=IDLE, dmem_resp=IDLE, state IDLE; post-reset LW completes normally.
